// File: rtl/mux41_rr_sched.sv
// mux41_rr_sched: round-robin, burst-bounded scheduler driving a MUX41's S1/S0/ENb
module mux41_rr_sched #(
  parameter int BURST_MAX = 8,
  parameter int CNT_W     = 8,
  parameter int GAP_EN    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       enb,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d, last_q, last_d, cur_q, cur_d;
  logic               enb_q, enb_d, busy_q, busy_d, rel;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         pick;
  // first requester after l in rotating order, l itself last; bit 2 = found
  function automatic logic [2:0] arb(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] c;
    arb = 3'b000;
    for (int j = 4; j >= 1; j--) begin
      c = l + 2'(j);
      if (r[c]) arb = {1'b1, c};
    end
  endfunction
  // next-state: hold/extend a burst, release into GAP, or (re)arbitrate
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    enb_d   = enb_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cur_d   = cur_q;
    rel     = !req[cur_q] || cnt_q == CNT_W'(BURST_MAX);
    pick    = arb(req, state_q == GRANT ? cur_q : last_q);
    if (state_q == GRANT && !rel) begin
      cnt_d = cnt_q + 1'b1;
    end else if (state_q == GRANT && GAP_EN != 0) begin
      last_d  = cur_q;
      state_d = GAP;
      gnt_d   = 4'b0000;
      enb_d   = 1'b1;
    end else begin
      if (state_q == GRANT) last_d = cur_q;
      state_d = pick[2] ? GRANT : IDLE;
      gnt_d   = pick[2] ? 4'b0001 << pick[1:0] : 4'b0000;
      enb_d   = !pick[2];
      sel_d   = pick[2] ? pick[1:0] : sel_q;
      cur_d   = pick[2] ? pick[1:0] : cur_q;
      cnt_d   = pick[2] ? CNT_W'(1) : cnt_q;
    end
    busy_d = state_d != IDLE;
  end
  // all state and outputs registered; last=3 puts req[0] first after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      enb_q   <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      cur_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      enb_q   <= enb_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
    end
  end
  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign enb  = enb_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_mux41_rr_sched.sv
// tb_mux41_rr_sched: three configurations checked against a behavioural scheduler model
module tb_mux41_rr_sched;
  localparam int BM [3] = '{8, 8, 4};
  localparam int GE [3] = '{1, 0, 1};
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt [3];
  logic [1:0] sel [3];
  logic       enb [3];
  logic       busy [3];
  int owner [3], run [3], last [3], msel [3];
  bit gap [3];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mux41_rr_sched #(.BURST_MAX(8), .CNT_W(8), .GAP_EN(1)) u0 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt[0]), .sel(sel[0]), .enb(enb[0]), .busy(busy[0]));
  mux41_rr_sched #(.BURST_MAX(8), .CNT_W(8), .GAP_EN(0)) u1 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt[1]), .sel(sel[1]), .enb(enb[1]), .busy(busy[1]));
  mux41_rr_sched #(.BURST_MAX(4), .CNT_W(3), .GAP_EN(1)) u2 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt[2]), .sel(sel[2]), .enb(enb[2]), .busy(busy[2]));

  function automatic int pick(input logic [3:0] r, input int l);
    for (int j = 1; j <= 4; j++)
      if (r[(l + j) % 4]) return (l + j) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      owner[k] = -1; run[k] = 0; last[k] = 3; msel[k] = 0; gap[k] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r);
    for (int k = 0; k < 3; k++) begin
      if (owner[k] >= 0) begin
        if (!r[owner[k]] || run[k] == BM[k]) begin
          last[k] = owner[k];
          if (GE[k] != 0) begin
            owner[k] = -1;
            gap[k] = 1;
          end else begin
            owner[k] = pick(r, last[k]);
            run[k] = 1;
            if (owner[k] >= 0) msel[k] = owner[k];
          end
        end else run[k]++;
      end else begin
        gap[k] = 0;
        owner[k] = pick(r, last[k]);
        run[k] = 1;
        if (owner[k] >= 0) msel[k] = owner[k];
      end
    end
  endtask

  task automatic check(input string tag);
    logic [3:0] eg;
    logic [1:0] es;
    logic eb, ey;
    for (int k = 0; k < 3; k++) begin
      eg = owner[k] >= 0 ? 4'(1 << owner[k]) : 4'b0000;
      es = 2'(msel[k]);
      eb = owner[k] < 0;
      ey = owner[k] >= 0 || gap[k];
      checks++;
      assert (gnt[k] === eg) else begin
        errors++;
        $error("FAIL %s u%0d gnt got %b want %b", tag, k, gnt[k], eg);
      end
      checks++;
      assert (sel[k] === es) else begin
        errors++;
        $error("FAIL %s u%0d sel got %b want %b", tag, k, sel[k], es);
      end
      checks++;
      assert (enb[k] === eb) else begin
        errors++;
        $error("FAIL %s u%0d enb got %b want %b", tag, k, enb[k], eb);
      end
      checks++;
      assert (busy[k] === ey) else begin
        errors++;
        $error("FAIL %s u%0d busy got %b want %b", tag, k, busy[k], ey);
      end
    end
  endtask

  task automatic cyc(input logic [3:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check(tag);
  endtask

  initial begin
    logic [3:0] r;
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    #3 check("reset");
    @(negedge clk);
    rst = 1'b0;
    check("reset_release");
    for (int i = 0; i < 3; i++) cyc(4'b0100, "pre_rst_grant");
    req = 4'b0100;
    @(posedge clk);
    model_step(req);
    #2 rst = 1'b1;
    #1 model_reset();
    check("async_rst_mid_grant");
    @(negedge clk);
    rst = 1'b0;
    check("after_rst");
    cyc(4'b0001, "post_rst_req0");
    for (int i = 0; i < 4; i++) cyc(4'b0000, "drain");
    for (int i = 0; i < 30; i++) cyc(4'b0100, "hold_req2");
    for (int i = 0; i < 3; i++) cyc(4'b0000, "drain");
    for (int i = 0; i < 45; i++) cyc(4'b1111, "all_req");
    for (int i = 0; i < 3; i++) cyc(4'b0000, "drain");
    for (int i = 0; i < 3; i++) cyc(4'b1010, "req1010");
    for (int i = 0; i < 12; i++) cyc(4'b1000, "req1_drop");
    for (int i = 0; i < 3; i++) cyc(4'b0000, "drain");
    for (int i = 0; i < 24; i++) cyc(4'b0101, "req0101");
    for (int i = 0; i < 3; i++) cyc(4'b0000, "drain");
    for (int i = 0; i < 3; i++) cyc(4'b1001, "burst_edge");
    cyc(4'b1000, "drop_at_max");
    for (int i = 0; i < 6; i++) cyc(4'b1000, "after_drop");
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cyc(r, "random");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
